// File: rtl/discrete_log_search_if.sv
// Request/response bundle for the discrete-log search engine.
// valid/ready: start is a request taken only while busy=0; done is a one-cycle completion pulse.
interface discrete_log_search_if #(
  parameter int W = 8
);
  logic         start;
  logic [W-1:0] X;
  logic [W-1:0] Y;
  logic [W-1:0] N;
  logic         busy;
  logic         done;
  logic         found;
  logic         err;
  logic [W-1:0] E;

  modport master (
    output start, X, Y, N,
    input  busy, done, found, err, E
  );

  modport slave (
    input  start, X, Y, N,
    output busy, done, found, err, E
  );
endinterface

// File: rtl/discrete_log_search.sv
// Finds the smallest E in 0..MAX_E with X^E mod N == Y mod N.
// It performs one modular multiply per clock.
module discrete_log_search #(
  parameter int W     = 8,
  parameter int MAX_E = 2**W - 1
) (
  input  logic                  clk,
  input  logic                  rst,
  discrete_log_search_if.slave  bus,
  output logic                  dbg_state
);
  typedef enum logic {IDLE = 1'b0, SEARCH = 1'b1} state_t;

  localparam logic [W-1:0] LAST_E = W'(MAX_E);

  state_t       state_q, state_d;
  logic [W-1:0] xm_q, xm_d;
  logic [W-1:0] ym_q, ym_d;
  logic [W-1:0] acc_q, acc_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] nr_q, nr_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         found_q, found_d;
  logic         err_q, err_d;
  logic [W-1:0] e_q, e_d;
  logic [2*W-1:0] prod;

  always_comb begin
    state_d = state_q;
    xm_d    = xm_q;
    ym_d    = ym_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    nr_d    = nr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    found_d = found_q;
    err_d   = err_q;
    e_d     = e_q;
    prod    = {{W{1'b0}}, acc_q} * {{W{1'b0}}, xm_q};

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.N != '0) begin
            xm_d    = bus.X % bus.N;
            ym_d    = bus.Y % bus.N;
            // 1 mod N is 0 only for N==1
            acc_d   = (bus.N == W'(1)) ? '0 : W'(1);
            cnt_d   = '0;
            nr_d    = bus.N;
            state_d = SEARCH;
            busy_d  = 1'b1;
            found_d = 1'b0;
            err_d   = 1'b0;
            e_d     = '0;
          end else begin
            done_d  = 1'b1;
            err_d   = 1'b1;
            found_d = 1'b0;
            e_d     = '0;
          end
        end
      end
      SEARCH: begin
        if (acc_q == ym_q) begin
          found_d = 1'b1;
          e_d     = cnt_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (cnt_q == LAST_E) begin
          found_d = 1'b0;
          e_d     = '0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          acc_d = W'(prod % {{W{1'b0}}, nr_q});
          cnt_d = cnt_q + W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      xm_q    <= '0;
      ym_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      nr_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      found_q <= 1'b0;
      err_q   <= 1'b0;
      e_q     <= '0;
    end else begin
      state_q <= state_d;
      xm_q    <= xm_d;
      ym_q    <= ym_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      nr_q    <= nr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      found_q <= found_d;
      err_q   <= err_d;
      e_q     <= e_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.found = found_q;
  assign bus.err   = err_q;
  assign bus.E     = e_q;
  assign dbg_state = (state_q == SEARCH);
endmodule

// File: tb/tb_discrete_log_search.sv
// Directed and random checks of discrete_log_search against a brute-force
// power-table model of the discrete logarithm.
module tb_discrete_log_search;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dbg_state;
  int   n_checks = 0;
  int   n_errors = 0;

  discrete_log_search_if #(.W(W)) bus ();

  discrete_log_search #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Walk X^0, X^1, ... mod N and return the first exponent hitting Y mod N.
  function automatic void ref_search(input int x, input int y, input int n,
                                     output int f, output int e, output int er,
                                     output int lat);
    int p;
    f = 0; e = 0; er = 0; lat = 256;
    if (n == 0) begin
      er = 1; lat = 0;
      return;
    end
    p = 1 % n;
    for (int k = 0; k <= 255; k++) begin
      if (p == y % n) begin
        f = 1; e = k; lat = k + 1;
        return;
      end
      p = (p * (x % n)) % n;
    end
  endfunction

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic launch(input int x, input int y, input int n);
    bus.X = W'(x);
    bus.Y = W'(y);
    bus.N = W'(n);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Waits for done (bounded) and checks latency, result and busy profile.
  task automatic finish_check(input string tag, input int x, input int y, input int n,
                              input int edges0);
    int ef, ee, er, el;
    int edges;
    logic busy_ok;
    ref_search(x, y, n, ef, ee, er, el);
    edges = edges0;
    busy_ok = 1'b1;
    while (bus.done !== 1'b1 && edges < 300) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      edges++;
    end
    check($sformatf("%s.latency", tag), edges, el);
    check($sformatf("%s.found", tag), bus.found, ef);
    check($sformatf("%s.E", tag), bus.E, ee);
    check($sformatf("%s.err", tag), bus.err, er);
    check($sformatf("%s.busy_during", tag), busy_ok, 1);
    check($sformatf("%s.busy_at_done", tag), bus.busy, 0);
  endtask

  initial begin
    int x, y, n;
    bus.start = 1'b0;
    bus.X = '0;
    bus.Y = '0;
    bus.N = '0;
    repeat (3) @(negedge clk);
    check("reset.busy", bus.busy, 0);
    check("reset.done", bus.done, 0);
    check("reset.found", bus.found, 0);
    check("reset.err", bus.err, 0);
    check("reset.E", bus.E, 0);
    check("reset.state", dbg_state, 0);
    rst = 1'b0;
    @(negedge clk);

    // Worked example from the datasheet: 3^3 = 27 = 6 mod 7
    launch(3, 6, 7);
    finish_check("x3y6n7", 3, 6, 7, 0);
    check("x3y6n7.E_const", bus.E, 3);
    @(negedge clk);
    check("x3y6n7.done_pulse", bus.done, 0);
    check("x3y6n7.E_hold", bus.E, 3);
    check("x3y6n7.found_hold", bus.found, 1);

    launch(3, 13, 7);
    finish_check("y_ge_n", 3, 13, 7, 0);
    check("y_ge_n.E_const", bus.E, 3);
    @(negedge clk);

    launch(2, 3, 7);
    finish_check("no_match", 2, 3, 7, 0);
    @(negedge clk);

    launch(5, 1, 0);
    finish_check("n_zero", 5, 1, 0, 0);
    check("n_zero.err_const", bus.err, 1);
    @(negedge clk);
    check("n_zero.done_pulse", bus.done, 0);
    check("n_zero.busy_after", bus.busy, 0);

    launch(9, 1, 13);
    finish_check("y_one", 9, 1, 13, 0);
    @(negedge clk);
    launch(5, 3, 1);
    finish_check("n_one", 5, 3, 1, 0);
    @(negedge clk);
    launch(14, 0, 7);
    finish_check("x_zero_mod", 14, 0, 7, 0);
    check("x_zero_mod.E_const", bus.E, 1);
    @(negedge clk);

    // Second start at edge 2 must be ignored: result stays 2^5 = 10 mod 11
    launch(2, 10, 11);
    @(negedge clk);
    bus.X = W'(3); bus.Y = W'(6); bus.N = W'(7);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    finish_check("ignore_start", 2, 10, 11, 2);
    check("ignore_start.E_const", bus.E, 5);
    @(negedge clk);

    // Reset sampled at edge 3 of a long search
    launch(2, 3, 7);
    @(negedge clk);
    check("rst_mid.done_e1", bus.done, 0);
    @(negedge clk);
    check("rst_mid.done_e2", bus.done, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid.busy", bus.busy, 0);
    check("rst_mid.done", bus.done, 0);
    check("rst_mid.found", bus.found, 0);
    check("rst_mid.E", bus.E, 0);
    check("rst_mid.err", bus.err, 0);
    check("rst_mid.state", dbg_state, 0);
    @(negedge clk);
    check("rst_mid.done_after", bus.done, 0);
    launch(3, 6, 7);
    finish_check("after_rst", 3, 6, 7, 0);

    // Back-to-back: new start presented during the done cycle
    @(negedge clk);
    launch(2, 10, 11);
    finish_check("b2b_first", 2, 10, 11, 0);
    launch(3, 13, 7);
    finish_check("b2b_second", 3, 13, 7, 0);
    @(negedge clk);

    for (int i = 0; i < 24; i++) begin
      x = int'($urandom_range(0, 255));
      y = int'($urandom_range(0, 255));
      n = (i % 2 == 0) ? int'($urandom_range(0, 24)) : int'($urandom_range(0, 255));
      launch(x, y, n);
      finish_check($sformatf("rand%0d_x%0d_y%0d_n%0d", i, x, y, n), x, y, n, 0);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
